// File: rtl/module_bin_bcd.sv
`default_nettype none
// ============================================================================
// module_bin_bcd : iterative double-dabble binary-to-BCD converter, 4 digits,
//                  inputs above MAX_VAL saturate to 9999.   Rev 1.0
// ============================================================================

module module_bin_bcd #(
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] binario,
  input  logic             start,
  output logic [3:0]       unidades_output,
  output logic [3:0]       decenas_output,
  output logic [3:0]       centenas_output,
  output logic [3:0]       millares_output,
  output logic             listo,
  output logic             busy,
  output logic             sat
);

  localparam int                BCD_W   = 16;
  localparam int                SR_W    = BCD_W + WIDTH;
  localparam int                CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0]  MAX_BIN = WIDTH'(MAX_VAL);
  localparam logic [CNT_W-1:0]  LAST_IT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SR_W-1:0]    shreg;
  logic [CNT_W-1:0]   count;
  logic               sat_flag;
  logic [BCD_W-1:0]   bcd_adj;
  logic               over;
  logic [WIDTH-1:0]   bin_clamped;

  assign over        = (binario > MAX_BIN);
  assign bin_clamped = over ? MAX_BIN : binario;

  // Add-3 correction on every BCD nibble before the shift; nibble is <= 9 here
  generate
    for (genvar i = 0; i < 4; i++) begin : g_adj
      logic [3:0] nib;
      assign nib                = shreg[WIDTH + 4*i +: 4];
      assign bcd_adj[4*i +: 4]  = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (count == LAST_IT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg           <= '0;
      count           <= '0;
      sat_flag        <= 1'b0;
      unidades_output <= 4'd0;
      decenas_output  <= 4'd0;
      centenas_output <= 4'd0;
      millares_output <= 4'd0;
      listo           <= 1'b0;
      busy            <= 1'b0;
      sat             <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= {{BCD_W{1'b0}}, bin_clamped};
            sat_flag <= over;
            count    <= '0;
            busy     <= 1'b1;
          end
        end
        CONV: begin
          shreg <= {bcd_adj, shreg[WIDTH-1:0]} << 1;
          count <= count + 1'b1;
        end
        DONE: begin
          unidades_output <= shreg[WIDTH      +: 4];
          decenas_output  <= shreg[WIDTH + 4  +: 4];
          centenas_output <= shreg[WIDTH + 8  +: 4];
          millares_output <= shreg[WIDTH + 12 +: 4];
          sat             <= sat_flag;
          listo           <= 1'b1;
          busy            <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_module_bin_bcd.sv
`default_nettype none
// ============================================================================
// tb_module_bin_bcd : directed self-checking bench for module_bin_bcd.
//                     Rev 1.0
// ============================================================================

module tb_module_bin_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] binario = '0;
  logic        start = 1'b0;
  logic [3:0]  unidades_output, decenas_output, centenas_output, millares_output;
  logic        listo, busy, sat;

  int passed = 0;
  int total  = 0;
  int listo_cnt = 0;

  module_bin_bcd #(.WIDTH(14), .MAX_VAL(9999)) dut (
    .clk             (clk),
    .rst             (rst),
    .binario         (binario),
    .start           (start),
    .unidades_output (unidades_output),
    .decenas_output  (decenas_output),
    .centenas_output (centenas_output),
    .millares_output (millares_output),
    .listo           (listo),
    .busy            (busy),
    .sat             (sat)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {millares_output, centenas_output, decenas_output, unidades_output};
  endfunction

  // Advance one edge and sample 1 ns later; every listo pulse is tallied
  task automatic tick();
    @(posedge clk);
    #1;
    if (listo) listo_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Accept at the next edge, expect digits 15 edges later, then check hold
  task automatic conv(input string tag, input logic [13:0] val,
                      input logic [15:0] exp_bcd, input logic exp_sat);
    int base;
    int busy_low;
    binario = val;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    base     = listo_cnt;
    busy_low = 0;
    repeat (14) begin
      tick();
      if (!busy) busy_low++;
    end
    chk({tag, "_early_listo"}, listo_cnt - base, 0);
    chk({tag, "_busy_held"}, busy_low, 0);
    tick();
    chk({tag, "_listo"}, listo, 1);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_digits"}, digits(), exp_bcd);
    chk({tag, "_sat"}, sat, exp_sat);
    tick();
    chk({tag, "_listo_drop"}, listo, 0);
    chk({tag, "_hold"}, digits(), exp_bcd);
  endtask

  initial begin
    int base;
    int bad;

    // Reset then idle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_digits", digits(), 16'h0000);
    chk("reset_flags", {listo, busy, sat}, 3'b000);
    bad = 0;
    repeat (20) begin
      tick();
      if (digits() !== 16'h0 || listo !== 1'b0 || busy !== 1'b0 || sat !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    conv("basic_7609", 14'd7609, 16'h7609, 1'b0);

    // Back-to-back: second start in the listo cycle of the first
    base    = listo_cnt;
    binario = 14'd3193;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (15) tick();
    chk("b2b_first_listo", listo, 1);
    chk("b2b_first_digits", digits(), 16'h3193);
    binario = 14'd94;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk("b2b_accept_busy", busy, 1);
    chk("b2b_accept_listo", listo, 0);
    repeat (14) tick();
    chk("b2b_no_early", listo_cnt - base, 1);
    tick();
    chk("b2b_second_listo", listo, 1);
    chk("b2b_second_digits", digits(), 16'h0094);
    repeat (5) tick();
    chk("b2b_two_pulses", listo_cnt - base, 2);

    conv("zero", 14'd0, 16'h0000, 1'b0);
    conv("max9999", 14'd9999, 16'h9999, 1'b0);
    conv("sat10000", 14'd10000, 16'h9999, 1'b1);
    conv("sat16383", 14'd16383, 16'h9999, 1'b1);

    // Start while busy is ignored; binario change mid-conversion has no effect
    base    = listo_cnt;
    binario = 14'd1234;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (4) tick();
    binario = 14'd5678;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (9) tick();
    chk("busy_ign_early", listo_cnt - base, 0);
    tick();
    chk("busy_ign_listo", listo, 1);
    chk("busy_ign_digits", digits(), 16'h1234);
    chk("busy_ign_sat", sat, 0);
    repeat (20) tick();
    chk("busy_ign_single", listo_cnt - base, 1);

    // Reset in the middle of a conversion
    base    = listo_cnt;
    binario = 14'd4321;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_digits", digits(), 16'h0000);
    chk("midrst_flags", {listo, busy, sat}, 3'b000);
    repeat (20) tick();
    chk("midrst_no_listo", listo_cnt - base, 0);
    conv("after_rst_42", 14'd42, 16'h0042, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
